// File: rtl/opb_register_bank.sv
// OPB slave exposing NUM_REGS byte-writable 32-bit registers to fabric logic.
// Ports: OPB_* bus inputs, Sl_* slave replies, user_data_out/user_wr_stb out.
module opb_register_bank #(
  parameter logic [31:0] C_BASEADDR = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR = 32'h000000FF,
  parameter int          NUM_REGS   = 4,
  parameter logic [31:0] INIT_VAL   = 32'h00000000,
  parameter logic [63:0] PULSE_MASK = 64'h0
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [0:31]              OPB_ABus,
  input  logic [0:3]               OPB_BE,
  input  logic [0:31]              OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:31]              Sl_DBus,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic                     Sl_xferAck,
  output logic [NUM_REGS*32-1:0]   user_data_out,
  output logic [NUM_REGS-1:0]      user_wr_stb
);

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  ACK  = 2'd1;
  localparam logic [1:0]  GAP  = 2'd2;
  localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

  logic [1:0]  state;
  logic [31:0] regs [NUM_REGS];
  logic [31:0] rdata;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [32:0] diff;
  logic [31:0] off;
  logic        hit;
  logic        start;
  logic [31:0] rd_word;
  logic [NUM_REGS-1:0] wr_sel;
  logic        unused;

  // MSB-first bus vectors land directly on [31:0] (bus bit k -> bit 31-k);
  // be[3] therefore covers bits 31:24.
  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;

  // 33-bit subtract: bit 32 flags an address below the base.
  assign diff  = {1'b0, addr} - {1'b0, C_BASEADDR};
  assign off   = diff[31:0];
  assign hit   = OPB_select && !diff[32] && (off <= SPAN);
  assign start = (state == IDLE) && hit;

  assign unused = ^{OPB_seqAddr, off[1:0]};

  always_comb begin
    rd_word = '0;
    wr_sel  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (off[31:2] == 30'(i)) begin
        rd_word   = regs[i];
        wr_sel[i] = start && !OPB_RNW;
      end
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    state <= hit ? ACK : IDLE;
        ACK:     state <= GAP;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lives only in the ACK cycle so Sl_DBus is zero otherwise.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      rdata       <= '0;
      user_wr_stb <= '0;
    end else begin
      rdata       <= (start && OPB_RNW) ? rd_word : '0;
      user_wr_stb <= wr_sel;
    end
  end

  // Pulse-mode registers fall back to INIT_VAL on every edge that does
  // not write them, so a written value is visible for the ACK cycle only.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) regs[i][8*b +: 8] <= wdata[8*b +: 8];
          end
        end else if (PULSE_MASK[i]) begin
          regs[i] <= INIT_VAL;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs[g];
  end

  assign Sl_DBus    = rdata;
  assign Sl_xferAck = (state == ACK);
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
// Self-checking bench for opb_register_bank: vector table, random
// transfers against a register-array model, and reset/back-to-back cases.
module tb_opb_register_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:31]  abus;
  logic [0:3]   be;
  logic [0:31]  dbus;
  logic         rnw;
  logic         sel;
  logic         seq;
  logic [0:31]  sl_dbus;
  logic         err_ack;
  logic         retry;
  logic         tout;
  logic         ack;
  logic [127:0] udo;
  logic [3:0]   stb;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [4];

  opb_register_bank #(
    .C_BASEADDR(32'h0),
    .C_HIGHADDR(32'hFF),
    .NUM_REGS(4),
    .INIT_VAL(32'h0),
    .PULSE_MASK(64'h1)
  ) dut (
    .OPB_Clk(clk),
    .OPB_Rst(rst),
    .OPB_ABus(abus),
    .OPB_BE(be),
    .OPB_DBus(dbus),
    .OPB_RNW(rnw),
    .OPB_select(sel),
    .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus),
    .Sl_errAck(err_ack),
    .Sl_retry(retry),
    .Sl_toutSup(tout),
    .Sl_xferAck(ack),
    .user_data_out(udo),
    .user_wr_stb(stb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rnw;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [31:0]  data;
    logic         eack;
    logic [31:0]  erd;
    logic [3:0]   estb;
    logic [127:0] eudo;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input string nm, input logic r,
                      input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic eack,
                      input logic [31:0] erd, input logic [3:0] estb,
                      input logic [127:0] eudo);
    @(negedge clk);
    sel = 1'b1; rnw = r; abus = a; be = b; dbus = d;
    @(posedge clk); #1;
    chk({nm, "_ack"}, 128'(ack), 128'(eack));
    chk({nm, "_rd"}, 128'(sl_dbus), 128'(erd));
    chk({nm, "_stb"}, 128'(stb), 128'(estb));
    chk({nm, "_udo"}, udo, eudo);
    @(negedge clk);
    sel = 1'b0; rnw = 1'b1; abus = '0; be = '0; dbus = '0;
    @(posedge clk); #1;
    chk({nm, "_gap_ack"}, 128'(ack), 128'(0));
    chk({nm, "_gap_rd"}, 128'(sl_dbus), 128'(0));
    chk({nm, "_gap_stb"}, 128'(stb), 128'(0));
    chk({nm, "_gap_udo"}, udo, eudo & ~128'hFFFF_FFFF);
    @(posedge clk);
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] r3,
      input logic [31:0] r2, input logic [31:0] r1, input logic [31:0] r0);
    return {r3, r2, r1, r0};
  endfunction

  task automatic model_xfer(input string nm, input logic r,
                            input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] d);
    logic        hitv;
    logic        inr;
    int          idx;
    logic [31:0] merged;
    logic [31:0] erd;
    logic [3:0]  estb;
    logic [31:0] w [4];
    hitv = (a <= 32'hFF);
    idx  = int'(a >> 2);
    inr  = hitv && (idx < 4);
    merged = inr ? m[idx] : 32'h0;
    for (int k = 0; k < 4; k++)
      if (b[k]) merged[8*k +: 8] = d[8*k +: 8];
    for (int k = 0; k < 4; k++) w[k] = m[k];
    erd  = 32'h0;
    estb = 4'h0;
    if (inr && r) erd = m[idx];
    if (inr && !r) begin
      w[idx] = merged;
      estb   = 4'(1 << idx);
      if (idx != 0) m[idx] = merged;
    end
    xfer(nm, r, a, b, d, hitv, erd, estb, pack4(w[3], w[2], w[1], w[0]));
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; rnw = 1'b1; abus = '0; be = '0;
    dbus = '0; seq = 1'b0;
    for (int k = 0; k < 4; k++) m[k] = 32'h0;

    #3;
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_rd", 128'(sl_dbus), 128'(0));
    chk("rst_stb", 128'(stb), 128'(0));
    chk("rst_udo", udo, 128'(0));
    chk("rst_tie", 128'({err_ack, retry, tout}), 128'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    vecs[0]  = '{1'b0, 32'h04, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0, 4'h2,
                 pack4(0, 0, 32'hDEADBEEF, 0)};
    vecs[1]  = '{1'b1, 32'h04, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 4'h0,
                 pack4(0, 0, 32'hDEADBEEF, 0)};
    vecs[2]  = '{1'b0, 32'h04, 4'h5, 32'h11223344, 1'b1, 32'h0, 4'h2,
                 pack4(0, 0, 32'hDE22BE44, 0)};
    vecs[3]  = '{1'b1, 32'h04, 4'hF, 32'h0, 1'b1, 32'hDE22BE44, 4'h0,
                 pack4(0, 0, 32'hDE22BE44, 0)};
    vecs[4]  = '{1'b0, 32'h00, 4'hF, 32'h1, 1'b1, 32'h0, 4'h1,
                 pack4(0, 0, 32'hDE22BE44, 1)};
    vecs[5]  = '{1'b1, 32'h00, 4'hF, 32'h0, 1'b1, 32'h0, 4'h0,
                 pack4(0, 0, 32'hDE22BE44, 0)};
    vecs[6]  = '{1'b0, 32'h10, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 4'h0,
                 pack4(0, 0, 32'hDE22BE44, 0)};
    vecs[7]  = '{1'b1, 32'h10, 4'hF, 32'h0, 1'b1, 32'h0, 4'h0,
                 pack4(0, 0, 32'hDE22BE44, 0)};
    vecs[8]  = '{1'b0, 32'h103, 4'hF, 32'h55555555, 1'b0, 32'h0, 4'h0,
                 pack4(0, 0, 32'hDE22BE44, 0)};
    vecs[9]  = '{1'b0, 32'h08, 4'h0, 32'h12345678, 1'b1, 32'h0, 4'h4,
                 pack4(0, 0, 32'hDE22BE44, 0)};
    vecs[10] = '{1'b0, 32'h0E, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0, 4'h8,
                 pack4(32'hCAFEF00D, 0, 32'hDE22BE44, 0)};
    vecs[11] = '{1'b1, 32'h0C, 4'hF, 32'h0, 1'b1, 32'hCAFEF00D, 4'h0,
                 pack4(32'hCAFEF00D, 0, 32'hDE22BE44, 0)};

    for (int i = 0; i < 12; i++)
      xfer($sformatf("vec%0d", i), vecs[i].rnw, vecs[i].addr, vecs[i].be,
           vecs[i].data, vecs[i].eack, vecs[i].erd, vecs[i].estb,
           vecs[i].eudo);

    // Reset asserted while ACK is high: ack drops at once, regs reinit.
    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = 32'h08; be = 4'hF; dbus = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("rstmid_pre_ack", 128'(ack), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("rstmid_ack", 128'(ack), 128'(0));
    chk("rstmid_stb", 128'(stb), 128'(0));
    chk("rstmid_udo", udo, 128'(0));
    @(negedge clk);
    sel = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_post_ack", 128'(ack), 128'(0));
    for (int k = 0; k < 4; k++) m[k] = 32'h0;

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 3));
      if (r == 9) a = a + 32'h100;
      else a = a + 32'(4 * (r % 6));
      model_xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a,
                 4'($urandom_range(0, 15)), $urandom);
    end

    // Select held across three reads: one ack every third cycle.
    @(negedge clk);
    sel = 1'b1; rnw = 1'b1; be = 4'hF; abus = 32'h04;
    for (int k = 0; k < 9; k++) begin
      logic expa;
      @(posedge clk); #1;
      expa = (k % 3 == 0);
      chk($sformatf("held_ack%0d", k), 128'(ack), 128'(expa));
      if (expa)
        chk($sformatf("held_rd%0d", k), 128'(sl_dbus),
            128'(m[k / 3 + 1]));
      @(negedge clk);
      if (expa) abus = 32'(4 * (k / 3 + 2));
    end
    sel = 1'b0;
    @(posedge clk); #1;
    chk("held_end_ack", 128'(ack), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_register_bank.md
Name: opb_register_bank

Overview:
- Parametrised successor to the single ppc2simulink software register.
- OPB slave exposing NUM_REGS 32-bit PPC-writable registers to fabric user logic.
- Each register supports byte-enabled writes and readback, with a per-register write strobe; each register is also selectable as level mode (holds its value) or pulse mode (self-clears after one cycle).
- Single clock domain: OPB_Clk; no user clock crossing inside this block.

Parameters:
- C_BASEADDR, 32'h00000000, first byte address of the slave window.
- C_HIGHADDR, 32'h000000FF, last byte address of the slave window; window must be at least NUM_REGS*4 bytes.
- NUM_REGS, 4, number of 32-bit registers, 1..64.
- INIT_VAL, 32'h00000000, reset value of every register; also the idle value of pulse-mode registers.
- PULSE_MASK, 64'h0, bit i = 1 makes register i pulse mode; bits at or above NUM_REGS are ignored.

Ports:
- OPB_Clk  in  1  bus and fabric clock
- OPB_Rst  in  1  reset, asynchronous, active-high
- OPB_ABus  in  [0:31]  byte address, bit 0 = MSB
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
- OPB_DBus  in  [0:31]  write data, bit 0 = MSB
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer valid
- OPB_seqAddr  in  1  sequential hint; ignored
- Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck = 0
- Sl_errAck  out  1  tied 0
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- Sl_xferAck  out  1  transfer acknowledge
- user_data_out  out  [NUM_REGS*32-1:0]  register i on bits [32*i+31 : 32*i], MSB-first
- user_wr_stb  out  [NUM_REGS-1:0]  one-cycle pulse when register i is written

Behaviour:
- Reset (OPB_Rst high, asynchronous) forces:
  - all registers to INIT_VAL;
  - Sl_xferAck = 0, Sl_DBus = 0, user_wr_stb = 0;
  - FSM to IDLE.
- Reset mid-transfer aborts the transfer with no ack; the master times out.
- Bit mapping: OPB_DBus[k] maps to register bit 31-k. BE[j] enables register bits [31-8j : 24-8j].
- Hit: OPB_select = 1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Register index: (OPB_ABus - C_BASEADDR) >> 2. ABus[30:31] are ignored.
- FSM states: IDLE, ACK, GAP.
  - IDLE: on a clock edge with hit, go to ACK. On that same edge:
    - write (RNW = 0): byte-enabled bytes of register[idx] are updated;
    - read (RNW = 1): Sl_DBus is loaded from register[idx].
  - ACK: Sl_xferAck = 1 for exactly one cycle; go to GAP unconditionally.
  - GAP: Sl_xferAck = 0 and Sl_DBus = 0; go to IDLE. GAP prevents a re-ack while the master drops select.
  - Latency: ack 1 cycle after select is sampled. Back-to-back transfers take 3 cycles each.
- Write with all BE = 0: still acked; register unchanged; user_wr_stb still pulses.
- Read data = register value at the sampling edge, i.e. before any same-cycle pulse clear.
- Index >= NUM_REGS, inside the window: acked normally; reads return 0; writes ignored; no strobe.
- user_wr_stb[i]: high during the ACK cycle of a write to i, coincident with the new value on user_data_out.
- Pulse-mode register: the written value appears on user_data_out for exactly the ACK cycle, then returns to INIT_VAL on the next edge. Reads normally return INIT_VAL.
- Level-mode register: holds its value until the next write or reset.
- Select without hit: no response, FSM stays IDLE.
- Select deasserted while in ACK or GAP: FSM completes the sequence regardless.

Test Plan:
- Reset -> all user_data_out words = INIT_VAL (0), Sl_xferAck = 0, Sl_DBus = 0, user_wr_stb = 0; assert reset mid-ACK -> ack drops immediately.
- Write 32'hDEADBEEF, BE = 4'b1111, to C_BASEADDR+4, then read back -> reg1 = DEADBEEF; ack exactly 1 cycle, 1 cycle after select; user_wr_stb = 4'b0010 in the ack cycle; read returns DEADBEEF, and Sl_DBus = 0 in GAP.
- Write 32'h11223344 with BE = 4'b0101 over reg1 = DEADBEEF -> reg1 = DE22BE44.
- PULSE_MASK = 1, write 32'h00000001 to reg0 -> user_data_out[31:0] = 1 for 1 cycle only, then 0; strobe coincident; subsequent read returns 0.
- NUM_REGS = 4, write to C_BASEADDR+16 (index 4, inside window) -> acked, no strobe, all regs unchanged; read returns 0. Address C_HIGHADDR+4 -> no ack.
- Select held continuously across 3 reads of different regs -> ack every 3rd cycle, correct data each time, no double ack.
